// File: rtl/mvu_pe_acc_bank_if.sv
// Stream bundle for mvu_pe_acc_bank: fold beats in, completed lane results out.
// The slave modport is the accumulator bank; the master modport is its driver.
interface mvu_pe_acc_bank_if #(
    parameter int PE        = 4,
    parameter int TDstI     = 16,
    parameter int TAccW     = 24,
    parameter int OUT_DEPTH = 4
);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic                  clr;
    logic                  in_v;
    logic                  in_ready;
    logic                  in_last;
    logic [PE*TDstI-1:0]   in_acc;
    logic                  out_v;
    logic                  out_ready;
    logic [PE*TAccW-1:0]   out_acc;
    logic [PE-1:0]         out_sat;
    logic [CW-1:0]         out_count;

    modport master (
        output clr, in_v, in_last, in_acc, out_ready,
        input  in_ready, out_v, out_acc, out_sat, out_count
    );

    modport slave (
        input  clr, in_v, in_last, in_acc, out_ready,
        output in_ready, out_v, out_acc, out_sat, out_count
    );
endinterface

// File: rtl/mvu_pe_acc_bank.sv
// Per-lane fold accumulators feeding a small result FIFO (valid/ready).
// Define MVU_ACC_SAT_EN to clamp lane additions and report out_sat.
module mvu_pe_acc_bank #(
    parameter int PE        = 4,
    parameter int TDstI     = 16,
    parameter int TAccW     = 24,
    parameter bit SIGNED    = 1'b1,
    parameter int OUT_DEPTH = 4
) (
    input logic              clock,
    input logic              resetn,
    mvu_pe_acc_bank_if.slave bus
);
    localparam int AW = PE * TAccW;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = $clog2(OUT_DEPTH);

    if (TAccW < TDstI) begin : g_chk_width
        $error("mvu_pe_acc_bank: TAccW must be >= TDstI");
    end
    if (OUT_DEPTH < 2) begin : g_chk_depth
        $error("mvu_pe_acc_bank: OUT_DEPTH must be >= 2");
    end

    logic             first_q, first_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    mem_q [OUT_DEPTH];
    logic [AW-1:0]    mem_d [OUT_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [AW-1:0]    sum;
    logic [TDstI-1:0] lane;
    logic [TAccW-1:0] ext;
    logic [TAccW-1:0] base;
    logic             beat;
    logic             push;
    logic             pop;

`ifdef MVU_ACC_SAT_EN
    logic [PE-1:0]    sat_q, sat_d;
    logic [PE-1:0]    msat_q [OUT_DEPTH];
    logic [PE-1:0]    msat_d [OUT_DEPTH];
    logic [PE-1:0]    clamp;
    logic [PE-1:0]    sat_new;
    logic [TAccW:0]   wide;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.in_ready  = !bus.clr && (count_q < CW'(OUT_DEPTH));
    assign beat          = bus.in_v && bus.in_ready;
    assign push          = beat && bus.in_last;
    assign pop           = bus.out_v && bus.out_ready;
    assign bus.out_v     = (count_q != '0);
    assign bus.out_acc   = mem_q[rd_ptr_q];
    assign bus.out_count = count_q;
`ifdef MVU_ACC_SAT_EN
    assign bus.out_sat   = msat_q[rd_ptr_q];
`else
    assign bus.out_sat   = '0;
`endif

    // The first beat of a fold starts from zero rather than the stale acc.
    always_comb begin
        sum  = '0;
        lane = '0;
        ext  = '0;
        base = '0;
`ifdef MVU_ACC_SAT_EN
        clamp = '0;
        wide  = '0;
`endif
        for (int i = 0; i < PE; i++) begin
            lane = bus.in_acc[i*TDstI +: TDstI];
            if (SIGNED) ext = TAccW'({{TAccW{lane[TDstI-1]}}, lane});
            else        ext = TAccW'(lane);
            base = first_q ? '0 : acc_q[i*TAccW +: TAccW];
`ifdef MVU_ACC_SAT_EN
            if (SIGNED) begin
                wide = {base[TAccW-1], base} + {ext[TAccW-1], ext};
                if (wide[TAccW] != wide[TAccW-1]) begin
                    clamp[i] = 1'b1;
                    wide[TAccW-1:0] = {wide[TAccW], {(TAccW-1){~wide[TAccW]}}};
                end
            end else begin
                wide = {1'b0, base} + {1'b0, ext};
                if (wide[TAccW]) begin
                    clamp[i] = 1'b1;
                    wide[TAccW-1:0] = '1;
                end
            end
            sum[i*TAccW +: TAccW] = wide[TAccW-1:0];
`else
            sum[i*TAccW +: TAccW] = base + ext;
`endif
        end
    end

    always_comb begin
        first_d  = first_q;
        acc_d    = acc_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
`ifdef MVU_ACC_SAT_EN
        sat_d    = sat_q;
        msat_d   = msat_q;
        sat_new  = (first_q ? '0 : sat_q) | clamp;
`endif
        if (bus.clr) begin
            first_d = 1'b1;
`ifdef MVU_ACC_SAT_EN
            sat_d   = '0;
`endif
        end else if (beat) begin
            if (bus.in_last) begin
                first_d         = 1'b1;
                mem_d[wr_ptr_q] = sum;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
`ifdef MVU_ACC_SAT_EN
                msat_d[wr_ptr_q] = sat_new;
`endif
            end else begin
                first_d = 1'b0;
                acc_d   = sum;
`ifdef MVU_ACC_SAT_EN
                sat_d   = sat_new;
`endif
            end
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            first_q  <= 1'b1;
            acc_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
`ifdef MVU_ACC_SAT_EN
            sat_q    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) msat_q[i] <= '0;
`endif
        end else begin
            first_q  <= first_d;
            acc_q    <= acc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
`ifdef MVU_ACC_SAT_EN
            sat_q    <= sat_d;
            msat_q   <= msat_d;
`endif
        end
    end
endmodule

// File: tb/tb_mvu_pe_acc_bank.sv
// Randomised and directed bench for mvu_pe_acc_bank against an integer fold model.
// Honours MVU_ACC_SAT_EN the same way the design does.
module tb_mvu_pe_acc_bank;
    localparam int PE = 4;
    localparam int DI = 16;
    localparam int AW = 24;
    localparam int D  = 4;

    typedef struct {
        logic [PE*AW-1:0] acc;
        logic [PE-1:0]    sat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvu_pe_acc_bank_if #(.PE(PE), .TDstI(DI), .TAccW(AW), .OUT_DEPTH(D)) b0 ();
    mvu_pe_acc_bank_if #(.PE(1), .TDstI(8), .TAccW(8), .OUT_DEPTH(2)) b1 ();
    mvu_pe_acc_bank_if #(.PE(1), .TDstI(8), .TAccW(10), .OUT_DEPTH(2)) b2 ();

    mvu_pe_acc_bank #(.PE(PE), .TDstI(DI), .TAccW(AW), .SIGNED(1'b1), .OUT_DEPTH(D))
        u0 (.clock(clk), .resetn(rst_n), .bus(b0.slave));
    mvu_pe_acc_bank #(.PE(1), .TDstI(8), .TAccW(8), .SIGNED(1'b1), .OUT_DEPTH(2))
        u1 (.clock(clk), .resetn(rst_n), .bus(b1.slave));
    mvu_pe_acc_bank #(.PE(1), .TDstI(8), .TAccW(10), .SIGNED(1'b0), .OUT_DEPTH(2))
        u2 (.clock(clk), .resetn(rst_n), .bus(b2.slave));

    int          n_chk = 0;
    int          n_fail = 0;
    res_t        m_q[$];
    bit          m_first = 1'b1;
    longint      m_acc[PE];
    logic [PE-1:0] m_sat = '0;

    // Add two integers, then clamp or wrap into the w-bit range.
    function automatic longint model_add(input longint a, input longint b,
                                         input int w, input bit sgn, output bit cl);
        longint s, m, lo, hi;
        s  = a + b;
        cl = 1'b0;
        m  = longint'(1) << w;
        lo = sgn ? -(m / 2) : 0;
        hi = sgn ? (m / 2 - 1) : (m - 1);
`ifdef MVU_ACC_SAT_EN
        if (s > hi) begin s = hi; cl = 1'b1; end
        else if (s < lo) begin s = lo; cl = 1'b1; end
`else
        if (s > hi || s < lo) begin
            s = (s - lo) % m;
            if (s < 0) s = s + m;
            s = s + lo;
        end
`endif
        return s;
    endfunction

    // Drive one cycle on the main DUT and advance the model across the edge.
    task automatic cycle(input bit v, input bit last, input logic [PE*DI-1:0] din,
                         input bit clr, input bit ordy);
        bit beat, pop, cl;
        longint s[PE];
        logic [PE-1:0] fl;
        logic signed [DI-1:0] x;
        res_t r;
        b0.in_v = v; b0.in_last = last; b0.in_acc = din;
        b0.clr = clr; b0.out_ready = ordy;
        beat = v && !clr && (m_q.size() < D);
        pop  = (m_q.size() != 0) && ordy;
        for (int i = 0; i < PE; i++) begin
            x = din[i*DI +: DI];
            s[i] = model_add(m_first ? 64'sd0 : m_acc[i], longint'(x), AW, 1'b1, cl);
            fl[i] = cl | (m_first ? 1'b0 : m_sat[i]);
            r.acc[i*AW +: AW] = AW'(s[i]);
        end
        r.sat = fl;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (clr) begin
            m_first = 1'b1;
            m_sat = '0;
        end else if (beat) begin
            if (last) begin
                m_q.push_back(r);
                m_first = 1'b1;
            end else begin
                m_first = 1'b0;
                m_sat = fl;
                for (int i = 0; i < PE; i++) m_acc[i] = s[i];
            end
        end
        @(negedge clk);
        #1;
    endtask

    function automatic logic [PE*DI-1:0] lane0(input int val, input bit rnd);
        logic [PE*DI-1:0] d;
        for (int i = 0; i < PE; i++) d[i*DI +: DI] = rnd ? DI'($urandom) : '0;
        d[0 +: DI] = DI'(val);
        return d;
    endfunction

    task automatic test_reset();
        if (b0.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready: got %b exp 1", b0.in_ready); end
        n_chk++;
        if (b0.out_v !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_v: got %b exp 0", b0.out_v); end
        n_chk++;
        if (b0.out_acc !== '0) begin n_fail++;
            $display("FAIL reset_out_acc: got %h exp 0", b0.out_acc); end
        n_chk++;
        if (b0.out_sat !== '0 || b0.out_count !== '0) begin n_fail++;
            $display("FAIL reset_sat_count: got %b/%0d exp 0/0", b0.out_sat, b0.out_count); end
        n_chk++;
    endtask

    task automatic test_fold();
        cycle(1, 0, lane0(5, 1), 0, 1);
        cycle(1, 0, lane0(-3, 1), 0, 1);
        cycle(1, 1, lane0(7, 1), 0, 1);
        if (b0.out_v !== 1'b1 || b0.out_acc[0 +: AW] !== AW'(9)) begin n_fail++;
            $display("FAIL fold_lane0: got v=%b %0d exp v=1 9", b0.out_v, b0.out_acc[0 +: AW]); end
        n_chk++;
        if (b0.out_acc !== m_q[0].acc) begin n_fail++;
            $display("FAIL fold_all: got %h exp %h", b0.out_acc, m_q[0].acc); end
        n_chk++;
        cycle(0, 0, '0, 0, 1);
        if (b0.out_v !== 1'b0 || b0.out_count !== 3'd0) begin n_fail++;
            $display("FAIL fold_drain: got v=%b cnt=%0d exp 0/0", b0.out_v, b0.out_count); end
        n_chk++;
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 3; k++) begin
            cycle(1, 1, lane0(k, 0), 0, 1);
            if (b0.out_acc !== {(PE*AW)'(k)} || b0.out_count !== 3'd1) begin n_fail++;
                $display("FAIL b2b_%0d: got %h cnt=%0d exp %0d cnt=1", k, b0.out_acc, b0.out_count, k); end
            n_chk++;
        end
        cycle(0, 0, '0, 0, 1);
        if (b0.out_count !== 3'd0) begin n_fail++;
            $display("FAIL b2b_empty: got %0d exp 0", b0.out_count); end
        n_chk++;
    endtask

    task automatic test_backpressure();
        int exp_v[5] = '{10, 11, 12, 13, 14};
        int idx = 0;
        bit sent = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (b0.in_ready !== (k < 4)) begin n_fail++;
                $display("FAIL bp_ready_%0d: got %b exp %b", k, b0.in_ready, k < 4); end
            n_chk++;
            cycle(1, 1, lane0(10 + k, 0), 0, 0);
        end
        if (b0.out_count !== 3'd4 || b0.out_acc[0 +: AW] !== AW'(10)) begin n_fail++;
            $display("FAIL bp_full: got cnt=%0d head=%0d exp 4/10", b0.out_count, b0.out_acc[0 +: AW]); end
        n_chk++;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            if (b0.in_ready !== (m_q.size() < D)) begin n_fail++;
                $display("FAIL bp_ready_drain: got %b exp %b", b0.in_ready, m_q.size() < D); end
            n_chk++;
            if (b0.out_v === 1'b1) begin
                if (b0.out_acc[0 +: AW] !== AW'(exp_v[idx])) begin n_fail++;
                    $display("FAIL bp_order_%0d: got %0d exp %0d", idx, b0.out_acc[0 +: AW], exp_v[idx]); end
                n_chk++;
                idx++;
            end
            if (!sent && m_q.size() < D) begin
                sent = 1'b1;
                cycle(1, 1, lane0(14, 0), 0, 1);
            end else begin
                cycle(!sent, 1, lane0(14, 0), 0, 1);
            end
        end
        if (idx != 5) begin n_fail++;
            $display("FAIL bp_timeout: got %0d results exp 5", idx); end
        n_chk++;
    endtask

    task automatic test_clr();
        cycle(1, 1, lane0(77, 0), 0, 0);
        cycle(1, 0, lane0(10, 0), 0, 0);
        cycle(1, 0, lane0(20, 0), 0, 0);
        cycle(1, 0, lane0(99, 0), 1, 0);
        if (b0.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL clr_ready: got %b exp 0", b0.in_ready); end
        n_chk++;
        cycle(1, 1, lane0(4, 0), 0, 0);
        if (b0.out_count !== 3'd2 || b0.out_acc[0 +: AW] !== AW'(77)) begin n_fail++;
            $display("FAIL clr_fifo: got cnt=%0d head=%0d exp 2/77", b0.out_count, b0.out_acc[0 +: AW]); end
        n_chk++;
        cycle(0, 0, '0, 0, 1);
        if (b0.out_acc !== {(PE*AW)'(4)} || b0.out_sat !== '0) begin n_fail++;
            $display("FAIL clr_result: got %h sat=%b exp 4 sat=0", b0.out_acc, b0.out_sat); end
        n_chk++;
        cycle(0, 0, '0, 0, 1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  lane0($urandom, 1), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) < 3);
            if (b0.in_ready !== (!b0.clr && m_q.size() < D)) begin n_fail++;
                $display("FAIL rnd_ready@%0d: got %b exp %b", c, b0.in_ready, !b0.clr && m_q.size() < D); end
            n_chk++;
            if (b0.out_count !== 3'(m_q.size()) || b0.out_v !== (m_q.size() != 0)) begin n_fail++;
                $display("FAIL rnd_count@%0d: got %0d v=%b exp %0d", c, b0.out_count, b0.out_v, m_q.size()); end
            n_chk++;
            if (m_q.size() != 0) begin
                if (b0.out_acc !== m_q[0].acc || b0.out_sat !== m_q[0].sat) begin n_fail++;
                    $display("FAIL rnd_head@%0d: got %h/%b exp %h/%b", c, b0.out_acc, b0.out_sat, m_q[0].acc, m_q[0].sat); end
                n_chk++;
            end
        end
        for (int c = 0; c < 8; c++) cycle(0, 0, '0, 1, 1);
    endtask

    task automatic test_overflow();
`ifdef MVU_ACC_SAT_EN
        logic [7:0] e_pos = 8'd127, e_neg = 8'h80;
        logic [9:0] e_u = 10'd1023;
        logic       e_s = 1'b1;
`else
        logic [7:0] e_pos = 8'hC8, e_neg = 8'd56;
        logic [9:0] e_u = 10'd251;
        logic       e_s = 1'b0;
`endif
        int vals[2] = '{100, -100};
        logic [7:0] exps[2];
        exps[0] = e_pos; exps[1] = e_neg;
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            b1.in_v = 1'b1; b1.in_acc = 8'(vals[f]); b1.in_last = 1'b0;
            cycle(0, 0, '0, 0, 1);
            b1.in_last = 1'b1;
            cycle(0, 0, '0, 0, 1);
            b1.in_v = 1'b0;
            #1;
            if (b1.out_v !== 1'b1 || b1.out_acc !== exps[f] || b1.out_sat !== e_s) begin n_fail++;
                $display("FAIL ovf_s8_%0d: got v=%b %h sat=%b exp %h sat=%b", f, b1.out_v, b1.out_acc, b1.out_sat, exps[f], e_s); end
            n_chk++;
            cycle(0, 0, '0, 0, 1);
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 2 + 3 * f; k++) begin
                b2.in_v = 1'b1; b2.in_acc = 8'hFF; b2.in_last = (k == 1 + 3 * f);
                cycle(0, 0, '0, 0, 1);
            end
            b2.in_v = 1'b0;
            #1;
            if (b2.out_v !== 1'b1 || b2.out_acc !== (f == 0 ? 10'd510 : e_u)
                || b2.out_sat !== (f == 0 ? 1'b0 : e_s)) begin n_fail++;
                $display("FAIL ovf_u10_%0d: got v=%b %0d sat=%b exp %0d", f, b2.out_v, b2.out_acc, b2.out_sat, f == 0 ? 10'd510 : e_u); end
            n_chk++;
            cycle(0, 0, '0, 0, 1);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 1, lane0(1, 0), 0, 0);
        cycle(1, 1, lane0(2, 0), 0, 0);
        cycle(1, 0, lane0(5, 0), 0, 0);
        b0.in_v = 1'b0;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        m_first = 1'b1;
        m_sat = '0;
        if (b0.out_v !== 1'b0 || b0.out_count !== 3'd0) begin n_fail++;
            $display("FAIL arst_now: got v=%b cnt=%0d exp 0/0", b0.out_v, b0.out_count); end
        n_chk++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cycle(1, 1, lane0(3, 0), 0, 1);
        if (b0.out_acc !== {(PE*AW)'(3)} || b0.out_count !== 3'd1) begin n_fail++;
            $display("FAIL arst_next: got %h cnt=%0d exp 3 cnt=1", b0.out_acc, b0.out_count); end
        n_chk++;
        cycle(0, 0, '0, 0, 1);
    endtask

    initial begin
        b0.clr = 0; b0.in_v = 0; b0.in_last = 0; b0.in_acc = '0; b0.out_ready = 0;
        b1.clr = 0; b1.in_v = 0; b1.in_last = 0; b1.in_acc = '0; b1.out_ready = 0;
        b2.clr = 0; b2.in_v = 0; b2.in_last = 0; b2.in_acc = '0; b2.out_ready = 0;
        for (int i = 0; i < PE; i++) m_acc[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_fold();
        test_back_to_back();
        test_backpressure();
        test_clr();
        test_random();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
